// File: rtl/mase_ctrl_pkg.sv
// mase_ctrl_pkg: shared control-path types for the MASE weight streaming blocks
package mase_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ws_state_t;

endpackage

// File: rtl/weight_stream_fifo.sv
// weight_stream_fifo: registered circular buffer holding ROM words until the consumer accepts them
module weight_stream_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic                              pop,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              empty
);

  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  do_pop;

  assign empty  = count == '0;
  assign do_pop = pop && !empty;
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on push, never reset (contents are gated by empty)
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end

endmodule

// File: rtl/weight_stream_sequencer.sv
// weight_stream_sequencer: streams the weight ROM cfg_passes times through a credit-limited output buffer
module weight_stream_sequencer
  import mase_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           cfg_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0]           FD   = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

  ws_state_t              state, state_d;
  logic [15:0]            passes_left;
  logic [CW-1:0]          inflight, fifo_count;
  logic [ROM_LATENCY-1:0] vld_sr;
  logic                   issue, push, pop, fifo_empty, last_addr, final_issue, drain_ok, done_d;

  assign rom_ce         = 1'b1;
  assign busy           = state != IDLE;
  assign push           = vld_sr[ROM_LATENCY-1];
  assign data_out_valid = !fifo_empty;
  assign pop            = data_out_valid && data_out_ready;
  assign issue          = state == RUN && ({1'b0, fifo_count} + {1'b0, inflight} < FD);
  assign last_addr      = rom_addr == LAST;
  assign final_issue    = issue && last_addr && passes_left == 16'd1;
  // The buffer counts as empty once this cycle's handshake takes its last word,
  // so done lands one cycle after the final handshake.
  assign drain_ok       = inflight == '0 && (fifo_empty || (fifo_count == CW'(1) && pop));

  // Next-state and completion pulse
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    unique case (state)
      IDLE:    if (start) state_d = cfg_passes != 16'd0 ? RUN : DRAIN;
      RUN:     if (final_issue) state_d = DRAIN;
      DRAIN:   if (drain_ok) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered done pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= done_d;
    end

  // Address generation, pass counting, in-flight tracking and ROM latency marker
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rom_addr    <= '0;
      passes_left <= '0;
      inflight    <= '0;
      vld_sr      <= '0;
    end else begin
      if (state == IDLE && start) begin
        rom_addr    <= '0;
        passes_left <= cfg_passes;
      end else if (issue) begin
        rom_addr <= last_addr ? '0 : rom_addr + 1'b1;
        if (last_addr) passes_left <= passes_left - 16'd1;
      end
      inflight <= inflight + CW'(issue) - CW'(push);
      vld_sr   <= (vld_sr << 1) | ROM_LATENCY'(issue);
    end

  weight_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rom_q),
    .pop   (pop),
    .dout  (data_out),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_weight_stream_sequencer.sv
// tb_weight_stream_sequencer: scoreboard bench for the weight stream sequencer
module tb_weight_stream_sequencer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH) + 1;

  logic          clk, rst, start, busy, done, rom_ce, data_out_valid, data_out_ready;
  logic [15:0]   cfg_passes;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out, rq0, rq1;

  int tests = 0, fails = 0, cyc = 0, c0 = 0;
  int hs_cnt = 0, done_cnt = 0, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  logic [DW-1:0] exp_q [$];

  weight_stream_sequencer #(
    .DATA_WIDTH (DW),
    .DEPTH (DEPTH),
    .ROM_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .start (start),
    .cfg_passes (cfg_passes),
    .busy (busy),
    .done (done),
    .rom_addr (rom_addr),
    .rom_ce (rom_ce),
    .rom_q (rom_q),
    .data_out (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  function automatic logic [DW-1:0] word(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_ce) begin
    rq0 <= word(int'(rom_addr));
    rq1 <= rq0;
  end
  assign rom_q = rq1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (data_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (data_out_valid && data_out_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word: got %0h expected nothing (queue empty)", data_out);
      end else check("word", data_out, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input int p);
    for (int i = 0; i < p; i++)
      for (int a = 0; a < DEPTH; a++) exp_q.push_back(word(a));
    hs_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    done_cyc = -1;
    start = 1'b1;
    cfg_passes = 16'(p);
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check({name, "_done_timeout"}, 32'(n), 32'(bound - 1));
    repeat (3) tick();
  endtask

  task automatic wait_hs(input int k, input int bound);
    int n = 0;
    while (hs_cnt < k && n < bound) begin
      tick();
      n++;
    end
    if (hs_cnt < k) check("hs_timeout", 32'(hs_cnt), 32'(k));
  endtask

  initial begin
    logic [AW-1:0] held;
    rst = 1'b0;
    start = 1'b0;
    cfg_passes = 16'd0;
    data_out_ready = 1'b1;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(data_out_valid), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", data_out, 0);
    rst = 1'b1;
    tick();

    // two passes, ready high
    start_stream(2);
    check("p2_busy_c1", 32'(busy), 1);
    check("p2_addr_c1", 32'(rom_addr), 0);
    tick();
    check("p2_addr_c2", 32'(rom_addr), 1);
    wait_done("p2", 100);
    check("p2_first_valid_cycle", 32'(first_valid_cyc - c0 + 1), 4);
    check("p2_hs", 32'(hs_cnt), 8);
    check("p2_done_cnt", 32'(done_cnt), 1);
    check("p2_done_after_last_hs", 32'(done_cyc - last_hs_cyc), 1);
    check("p2_left", 32'(exp_q.size()), 0);
    check("p2_idle", 32'(busy), 0);

    // zero passes
    start_stream(0);
    check("z_busy_c1", 32'(busy), 1);
    check("z_done_c1", 32'(done), 0);
    tick();
    check("z_busy_c2", 32'(busy), 0);
    check("z_done_c2", 32'(done), 1);
    tick();
    check("z_done_c3", 32'(done), 0);
    check("z_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    check("z_addr", 32'(rom_addr), 0);

    // ready stalled 20 cycles mid-stream
    start_stream(3);
    wait_hs(3, 50);
    data_out_ready = 1'b0;
    repeat (10) tick();
    held = rom_addr;
    repeat (10) tick();
    check("stall_fifo_full", 32'(dut.fifo_count), 4);
    check("stall_inflight", 32'(dut.inflight), 0);
    check("stall_addr_held", 32'(rom_addr), 32'(held));
    check("stall_valid", 32'(data_out_valid), 1);
    data_out_ready = 1'b1;
    wait_done("stall", 100);
    check("stall_hs", 32'(hs_cnt), 12);
    check("stall_done_cnt", 32'(done_cnt), 1);
    check("stall_left", 32'(exp_q.size()), 0);

    // ready toggling, 96 words
    start_stream(24);
    for (int n = 0; n < 1000 && done_cnt == 0; n++) begin
      data_out_ready = ~data_out_ready;
      tick();
    end
    data_out_ready = 1'b1;
    wait_done("tog", 10);
    check("tog_hs", 32'(hs_cnt), 96);
    check("tog_done_cnt", 32'(done_cnt), 1);
    check("tog_done_after_last_hs", 32'(done_cyc - last_hs_cyc), 1);
    check("tog_left", 32'(exp_q.size()), 0);

    // reset in the middle of pass 2
    start_stream(3);
    wait_hs(5, 50);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(data_out_valid), 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_addr", 32'(rom_addr), 0);
    check("mid_rst_done", 32'(done), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", 32'(done_cnt), 0);
    start_stream(1);
    wait_done("after_rst", 100);
    check("after_rst_hs", 32'(hs_cnt), 4);
    check("after_rst_done_cnt", 32'(done_cnt), 1);
    check("after_rst_left", 32'(exp_q.size()), 0);

    // start pulsed while busy
    start_stream(2);
    tick();
    start = 1'b1;
    cfg_passes = 16'd5;
    tick();
    start = 1'b0;
    wait_done("busy_start", 100);
    repeat (10) tick();
    check("busy_start_hs", 32'(hs_cnt), 8);
    check("busy_start_done_cnt", 32'(done_cnt), 1);
    check("busy_start_left", 32'(exp_q.size()), 0);
    check("busy_start_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
